// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types and defaults for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Read/write/clear bundle between the pipeline and regfile_mp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);

    logic                clr;
    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;

    modport master (
        output clr, rd_addr, we, wr_addr, wr_data,
        input  ready, rd_data
    );

    modport slave (
        input  clr, rd_addr, we, wr_addr, wr_data,
        output ready, rd_data
    );

endinterface

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// Module   : regfile_rd_port
// Brief    : One read port: x0 masking, ready gating, optional write bypass.
//            Bypass mux present only when REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rd_port #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 1
) (
    input  wire logic            ready,
    input  wire logic [AW-1:0]   rd_addr,
    input  wire logic [XLEN-1:0] arr_data,
    output logic      [XLEN-1:0] rd_data
`ifdef REGFILE_BYPASS_EN
    ,
    input  wire logic                byp_en,
    input  wire logic [NWR-1:0]      we,
    input  wire logic [NWR*AW-1:0]   wr_addr,
    input  wire logic [NWR*XLEN-1:0] wr_data
`endif
);

    always_comb begin
        rd_data = '0;
        if (ready && (rd_addr != '0)) begin
            rd_data = arr_data;
`ifdef REGFILE_BYPASS_EN
            // Higher-numbered write port overrides, matching the array's collision rule
            for (int p = 0; p < NWR; p++) begin
                if (byp_en && we[p] && (wr_addr[p*AW +: AW] == rd_addr)) begin
                    rd_data = wr_data[p*XLEN +: XLEN];
                end
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : NRD-read / NWR-write integer register file with x0 hardwired to
//            zero and a sequential clear engine. Option: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regfile_mp_if.slave bus
);

    localparam int            AW     = $clog2(NREGS);
    localparam logic [AW-1:0] c_last = AW'(NREGS - 1);

    rf_state_e        r_state;
    rf_state_e        w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic             r_ready;
    logic             w_wr_en;
    logic [XLEN-1:0]  r_regs [1:NREGS-1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        case (r_state)
            CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // A clear request wins over any write in the same cycle
                if (bus.clr) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = AW'(1);
                end else begin
                    w_wr_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = AW'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= AW'(1);
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_regs[r_cnt] <= '0;
            end else if (w_wr_en) begin
                for (int p = 0; p < NWR; p++) begin
                    if (bus.we[p] && (bus.wr_addr[p*AW +: AW] != '0)) begin
                        r_regs[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    assign bus.ready = r_ready;

`ifdef REGFILE_BYPASS_EN
    logic w_byp_en;
    assign w_byp_en = r_ready & ~bus.clr;
`endif

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;

            assign w_addr = bus.rd_addr[i*AW +: AW];

            regfile_rd_port #(
                .XLEN (XLEN),
                .AW   (AW),
                .NWR  (NWR)
            ) u_rd_port (
                .ready    (r_ready),
                .rd_addr  (w_addr),
                .arr_data (r_regs[w_addr]),
                .rd_data  (w_data)
`ifdef REGFILE_BYPASS_EN
                ,
                .byp_en   (w_byp_en),
                .we       (bus.we),
                .wr_addr  (bus.wr_addr),
                .wr_data  (bus.wr_data)
`endif
            );

            assign bus.rd_data[i*XLEN +: XLEN] = w_data;
        end
    endgenerate

endmodule

`default_nettype wire
